// File: rtl/iir_biquad_cascade.sv
// Cascade of direct-form-I biquad sections sharing one multiply-accumulate unit.
// One sample is in flight at a time; coefficients sit in a register file with combinational readback.
module iir_biquad_cascade #(
  parameter int DATA_WIDTH   = 16,
  parameter int DATA_FRAC    = 15,
  parameter int COEFF_WIDTH  = 20,
  parameter int COEFF_FRAC   = 18,
  parameter int NUM_SECTIONS = 2,
  parameter int ADDR_WIDTH   = $clog2(5 * NUM_SECTIONS),
  parameter int ACC_WIDTH    = DATA_WIDTH + COEFF_WIDTH + 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   bypass,
  input  logic                   flush,
  input  logic                   coeff_wr_en,
  input  logic [ADDR_WIDTH-1:0]  coeff_addr,
  input  logic [COEFF_WIDTH-1:0] coeff_wdata,
  output logic [COEFF_WIDTH-1:0] coeff_rdata,
  output logic                   coeff_wr_err,
  output logic                   valid_out,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int NUM_COEFFS = 5 * NUM_SECTIONS;
  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
  localparam int SEC_WIDTH  = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_RND  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic [COEFF_WIDTH-1:0]      COEFF_ONE    = COEFF_WIDTH'(1) << COEFF_FRAC;
  localparam logic signed [ACC_WIDTH-1:0] ROUND_HALF   = ACC_WIDTH'(1) << (COEFF_FRAC - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX      = ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN      = ~SAT_MAX;
  localparam logic [SEC_WIDTH-1:0]        LAST_SECTION = SEC_WIDTH'(NUM_SECTIONS - 1);

  logic [1:0]                          state_reg;
  logic [SEC_WIDTH-1:0]                section_reg;
  logic [2:0]                          tap_reg;
  logic signed [ACC_WIDTH-1:0]         acc_reg;
  logic signed [ACC_WIDTH-1:0]         acc_next;
  logic signed [DATA_WIDTH-1:0]        x_cur_reg;
  logic                                ovf_sticky_reg;
  logic                                unf_sticky_reg;
  logic [DATA_WIDTH-1:0]               data_out_reg;
  logic                                overflow_reg;
  logic                                underflow_reg;
  logic                                wr_err_reg;

  logic [NUM_COEFFS*COEFF_WIDTH-1:0]   coeff_flat;
  logic [NUM_SECTIONS*DATA_WIDTH-1:0]  x1_flat;
  logic [NUM_SECTIONS*DATA_WIDTH-1:0]  x2_flat;
  logic [NUM_SECTIONS*DATA_WIDTH-1:0]  y1_flat;
  logic [NUM_SECTIONS*DATA_WIDTH-1:0]  y2_flat;

  logic                                accept;
  logic                                coeff_addr_ok;
  logic                                coeff_we;
  logic                                in_rnd;
  logic                                last_section;
  int                                  mac_idx;
  logic signed [COEFF_WIDTH-1:0]       coeff_sel;
  logic signed [DATA_WIDTH-1:0]        data_sel;
  logic signed [DATA_WIDTH-1:0]        x1_cur;
  logic signed [DATA_WIDTH-1:0]        x2_cur;
  logic signed [DATA_WIDTH-1:0]        y1_cur;
  logic signed [DATA_WIDTH-1:0]        y2_cur;
  logic signed [PROD_WIDTH-1:0]        prod;
  logic signed [ACC_WIDTH-1:0]         rnd_sum;
  logic signed [ACC_WIDTH-1:0]         rnd_shift;
  logic signed [DATA_WIDTH-1:0]        y_sat;
  logic                                sat_hi;
  logic                                sat_lo;

  // OUT behaves like IDLE for sample acceptance so samples can run back to back.
  assign ready_in      = (state_reg == ST_IDLE) || (state_reg == ST_OUT);
  assign accept        = ready_in && valid_in && !flush;
  assign coeff_addr_ok = int'(coeff_addr) < NUM_COEFFS;
  assign coeff_we      = coeff_wr_en && (state_reg == ST_IDLE) && coeff_addr_ok;
  assign in_rnd        = (state_reg == ST_RND);
  assign last_section  = (section_reg == LAST_SECTION);
  assign mac_idx       = int'(section_reg) * 5 + int'(tap_reg);

  genvar gi;

  generate
    for (gi = 0; gi < NUM_COEFFS; gi++) begin : g_coeff
      logic [COEFF_WIDTH-1:0] coeff_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          coeff_q <= (gi % 5 == 0) ? COEFF_ONE : '0;
        end else if (coeff_we && int'(coeff_addr) == gi) begin
          coeff_q <= coeff_wdata;
        end
      end

      assign coeff_flat[gi*COEFF_WIDTH +: COEFF_WIDTH] = coeff_q;
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_SECTIONS; gi++) begin : g_section
      logic [DATA_WIDTH-1:0] x1_q;
      logic [DATA_WIDTH-1:0] x2_q;
      logic [DATA_WIDTH-1:0] y1_q;
      logic [DATA_WIDTH-1:0] y2_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x1_q <= '0;
          x2_q <= '0;
          y1_q <= '0;
          y2_q <= '0;
        end else if (flush) begin
          x1_q <= '0;
          x2_q <= '0;
          y1_q <= '0;
          y2_q <= '0;
        end else if (in_rnd && section_reg == SEC_WIDTH'(gi)) begin
          x2_q <= x1_q;
          x1_q <= x_cur_reg;
          y2_q <= y1_q;
          y1_q <= y_sat;
        end
      end

      assign x1_flat[gi*DATA_WIDTH +: DATA_WIDTH] = x1_q;
      assign x2_flat[gi*DATA_WIDTH +: DATA_WIDTH] = x2_q;
      assign y1_flat[gi*DATA_WIDTH +: DATA_WIDTH] = y1_q;
      assign y2_flat[gi*DATA_WIDTH +: DATA_WIDTH] = y2_q;
    end
  endgenerate

  always_comb begin
    coeff_rdata = '0;
    for (int i = 0; i < NUM_COEFFS; i++) begin
      if (int'(coeff_addr) == i) begin
        coeff_rdata = coeff_flat[i*COEFF_WIDTH +: COEFF_WIDTH];
      end
    end
  end

  always_comb begin
    coeff_sel = '0;
    for (int i = 0; i < NUM_COEFFS; i++) begin
      if (mac_idx == i) begin
        coeff_sel = coeff_flat[i*COEFF_WIDTH +: COEFF_WIDTH];
      end
    end
  end

  always_comb begin
    x1_cur = '0;
    x2_cur = '0;
    y1_cur = '0;
    y2_cur = '0;
    for (int i = 0; i < NUM_SECTIONS; i++) begin
      if (int'(section_reg) == i) begin
        x1_cur = x1_flat[i*DATA_WIDTH +: DATA_WIDTH];
        x2_cur = x2_flat[i*DATA_WIDTH +: DATA_WIDTH];
        y1_cur = y1_flat[i*DATA_WIDTH +: DATA_WIDTH];
        y2_cur = y2_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    data_sel = x_cur_reg;
    case (tap_reg)
      3'd1:    data_sel = x1_cur;
      3'd2:    data_sel = x2_cur;
      3'd3:    data_sel = y1_cur;
      3'd4:    data_sel = y2_cur;
      default: data_sel = x_cur_reg;
    endcase
  end

  assign prod = PROD_WIDTH'(coeff_sel) * PROD_WIDTH'(data_sel);

  // Feedback taps (a1, a2) are subtracted; tap 0 starts a fresh sum.
  always_comb begin
    acc_next = acc_reg;
    case (tap_reg)
      3'd0:       acc_next = ACC_WIDTH'(prod);
      3'd1, 3'd2: acc_next = acc_reg + ACC_WIDTH'(prod);
      default:    acc_next = acc_reg - ACC_WIDTH'(prod);
    endcase
  end

  assign rnd_sum   = acc_reg + ROUND_HALF;
  assign rnd_shift = rnd_sum >>> COEFF_FRAC;

  always_comb begin
    sat_hi = 1'b0;
    sat_lo = 1'b0;
    y_sat  = rnd_shift[DATA_WIDTH-1:0];
    if (rnd_shift > SAT_MAX) begin
      sat_hi = 1'b1;
      y_sat  = SAT_MAX[DATA_WIDTH-1:0];
    end else if (rnd_shift < SAT_MIN) begin
      sat_lo = 1'b1;
      y_sat  = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      section_reg    <= '0;
      tap_reg        <= '0;
      acc_reg        <= '0;
      x_cur_reg      <= '0;
      ovf_sticky_reg <= 1'b0;
      unf_sticky_reg <= 1'b0;
      data_out_reg   <= '0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
    end else if (flush) begin
      // Aborted sample: outputs keep the last delivered result.
      state_reg <= ST_IDLE;
      acc_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_OUT: begin
          state_reg <= ST_IDLE;
          if (accept) begin
            x_cur_reg      <= data_in;
            ovf_sticky_reg <= 1'b0;
            unf_sticky_reg <= 1'b0;
            section_reg    <= '0;
            tap_reg        <= '0;
            if (bypass) begin
              data_out_reg  <= data_in;
              overflow_reg  <= 1'b0;
              underflow_reg <= 1'b0;
              state_reg     <= ST_OUT;
            end else begin
              state_reg <= ST_MAC;
            end
          end
        end
        ST_MAC: begin
          acc_reg <= acc_next;
          if (tap_reg == 3'd4) begin
            tap_reg   <= '0;
            state_reg <= ST_RND;
          end else begin
            tap_reg <= tap_reg + 3'd1;
          end
        end
        ST_RND: begin
          x_cur_reg      <= y_sat;
          ovf_sticky_reg <= ovf_sticky_reg | sat_hi;
          unf_sticky_reg <= unf_sticky_reg | sat_lo;
          if (last_section) begin
            data_out_reg  <= y_sat;
            overflow_reg  <= ovf_sticky_reg | sat_hi;
            underflow_reg <= unf_sticky_reg | sat_lo;
            state_reg     <= ST_OUT;
          end else begin
            section_reg <= section_reg + SEC_WIDTH'(1);
            state_reg   <= ST_MAC;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_reg <= 1'b0;
    end else begin
      wr_err_reg <= coeff_wr_en && !coeff_we;
    end
  end

  assign valid_out    = (state_reg == ST_OUT);
  assign data_out     = data_out_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;
  assign coeff_wr_err = wr_err_reg;

endmodule

// File: doc/iir_biquad_cascade.md
# iir_biquad_cascade

Parametrised cascade of NUM_SECTIONS direct-form-I biquad sections sharing one time-multiplexed multiplier-accumulator, with a per-sample handshake, run-time addressable coefficient RAM, and bypass and flush controls. It sits in the DFE chain at the slot of the single-stage notch IIR. Multi-notch or higher-order responses are built by cascading sections instead of instantiating several fixed filters.

## Interface
- DATA_WIDTH, 16, sample width, signed Q(DATA_WIDTH-DATA_FRAC).DATA_FRAC
- DATA_FRAC, 15, sample fractional bits
- COEFF_WIDTH, 20, coefficient width, signed
- COEFF_FRAC, 18, coefficient fractional bits; COEFF_WIDTH-COEFF_FRAC >= 2 required
- NUM_SECTIONS, 2, number of cascaded biquads, >= 1
- ADDR_WIDTH, $clog2(5*NUM_SECTIONS), coefficient address width
- ACC_WIDTH, DATA_WIDTH+COEFF_WIDTH+3, accumulator width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- valid_in  in  1  input sample valid
- ready_in  out  1  block can accept a sample
- data_in  in  DATA_WIDTH  input sample
- bypass  in  1  sampled at accept: pass data_in through unfiltered
- flush  in  1  clear all delay lines / abort current sample
- coeff_wr_en  in  1  coefficient write strobe
- coeff_addr  in  ADDR_WIDTH  address = section*5 + tap (0 b0, 1 b1, 2 b2, 3 a1, 4 a2)
- coeff_wdata  in  COEFF_WIDTH  write data
- coeff_rdata  out  COEFF_WIDTH  combinational readback of coeff_addr; 0 if address is out of range
- coeff_wr_err  out  1  one-cycle pulse: write rejected
- valid_out  out  1  one-cycle output valid pulse
- data_out  out  DATA_WIDTH  filtered sample, held until next valid_out
- overflow  out  1  any section saturated positive on this sample, held with data_out
- underflow  out  1  any section saturated negative on this sample, held with data_out

## Operation
- Per section s: y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2.
- Section s input x is section s−1 output (saturated); section 0 input is data_in.
- Delay lines x1,x2,y1,y2 per section, reset and flush value 0.
- Coefficient reset value per section: b0 = 1<<COEFF_FRAC (1.0), others 0. At reset the block is a pure passthrough.
- Products: full DATA_WIDTH+COEFF_WIDTH signed. Accumulate sign-extended into ACC_WIDTH.
- Round/saturate: add 1<<(COEFF_FRAC−1), arithmetic shift right COEFF_FRAC, clamp to [−2^(DW−1), 2^(DW−1)−1]. Clamp high sets the sticky-per-sample overflow; clamp low sets underflow.
- FSM states: IDLE, MAC, RND, OUT.
  - IDLE: ready_in=1. On valid_in latch data_in and bypass.
    - bypass=1: go to OUT. data_out=data_in, flags 0, delay lines untouched.
    - bypass=0: go to MAC, section=0, tap=0.
  - MAC: one multiply-accumulate per cycle, tap 0..4. After tap 4 go to RND.
  - RND: round/saturate, shift the section's delay lines (x2←x1, x1←x, y2←y1, y1←y), forward y.
    - Not last section: section+1, go to MAC.
    - Last section: go to OUT.
  - OUT: register data_out, overflow, underflow; pulse valid_out; go to IDLE.
- Coefficient writes are accepted only when the FSM is in IDLE and coeff_addr < 5·NUM_SECTIONS. Otherwise there is no write and coeff_wr_err pulses the next cycle.
- A write and a sample accept in the same IDLE cycle are both taken; the sample uses the new coefficient.
- flush (any state): clear all delay lines and the accumulator, go to IDLE next cycle. No valid_out for the aborted sample. data_out and flags keep their previous values.
- flush with valid_in in the same cycle: flush wins, the sample is dropped, ready_in is 1 again next cycle.

## Timing
- Reset values: ready_in=1, valid_out=0, data_out=0, overflow=0, underflow=0, coeff_wr_err=0. FSM in IDLE.
- Accept at cycle T (valid_in && ready_in).
- Filtered: valid_out at T+6·NUM_SECTIONS+1 (13 for NUM_SECTIONS=2).
- Bypass: valid_out at T+1.
- ready_in=0 from T+1 until the cycle valid_out is high. It is 1 in that cycle, so a back-to-back accept is possible there.
- Throughput: one sample per 6·NUM_SECTIONS+1 cycles.
- valid_in while ready_in=0 is ignored (no queueing).

## Test plan
- Reset defaults, NUM_SECTIONS=2, data_in=0x4000 → data_out=0x4000 at T+13, flags 0. Then data_in=0x8000 → 0x8000.
- Write b0=0x20000 (0.5) to both sections. Input 0x4000 → 0x1000. Readback coeff_addr=5 returns 0x20000.
- Section 0: b0=0x7FFFF, input 0x7FFF → 0x7FFF with overflow=1. Input 0x8000 → 0x8000 with underflow=1.
- Section 0: a1=0xE0000 (−0.5). Impulse 0x4000 then zeros → outputs 0x4000, 0x2000, 0x1000, 0x0800.
- Write during MAC → coeff_wr_err pulse and readback unchanged. Write to address 10 (NUM_SECTIONS=2) → coeff_wr_err.
- flush asserted at T+4 → no valid_out. Next impulse with the recursive coefficients restarts at 0x4000 (delay lines cleared).
- bypass=1 with data_in=0x1234 → 0x1234 at T+1. The following filtered sample shows the history unchanged.
